// File: rtl/mem_wb_commit_pkg.sv
// Shared pipeline definitions for the MEM->WB boundary: bus widths,
// enable/stall encodings and the write-back entry layout.
package mem_wb_commit_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic                  RstEnable    = 1'b1;
  localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic                  Stop         = 1'b1;
  localparam logic                  NoStop       = 1'b0;

  localparam int StallMemBit = 4;
  localparam int StallWbBit  = 5;

  typedef struct packed {
    logic                  valid;
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
    logic [RegBus-1:0]     flags;
  } wb_entry_t;

  // A reset entry and a bubble are the same all-zero, invalid entry.
  localparam wb_entry_t EmptyEntry = '{
    valid: 1'b0,
    wd:    NOPRegAddr,
    wreg:  WriteDisable,
    wdata: ZeroWord,
    hi:    ZeroWord,
    lo:    ZeroWord,
    whilo: WriteDisable,
    flags: ZeroWord
  };

endpackage

// File: rtl/mem_wb_commit_hilo_flags_reg.sv
// Architected HI/LO/FLAGS registers, written only on a commit strobe
// with separate enables for the HI/LO pair and for FLAGS.
module hilo_flags_reg
  import mem_wb_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_i,
  input  logic              hiloEn_i,
  input  logic              flagsEn_i,
  input  logic [RegBus-1:0] hi_i,
  input  logic [RegBus-1:0] lo_i,
  input  logic [RegBus-1:0] flags_i,
  output logic [RegBus-1:0] hi_o,
  output logic [RegBus-1:0] lo_o,
  output logic [RegBus-1:0] flags_o
);

  logic [RegBus-1:0] hi_q, lo_q, flags_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q    <= ZeroWord;
      lo_q    <= ZeroWord;
      flags_q <= ZeroWord;
    end else if (commit_i) begin
      if (hiloEn_i == WriteEnable) begin
        hi_q <= hi_i;
        lo_q <= lo_i;
      end
      if (flagsEn_i == WriteEnable) begin
        flags_q <= flags_i;
      end
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/mem_wb_commit.sv
// MEM->WB boundary register plus architected HI/LO/FLAGS commit.
// Optional feature macro: RETIRE_CNT_EN adds the retire_cnt port and counter.
module mem_wb_commit
  import mem_wb_commit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [RegBus-1:0]     mem_hi,
  input  logic [RegBus-1:0]     mem_lo,
  input  logic                  mem_whilo,
  input  logic [RegBus-1:0]     mem_flags,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic [RegBus-1:0]     wb_hi,
  output logic [RegBus-1:0]     wb_lo,
  output logic                  wb_whilo,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic [RegBus-1:0]     flags_o
`ifdef RETIRE_CNT_EN
  ,
  output logic [RegBus-1:0]     retire_cnt
`endif
);

  wb_entry_t entry_q, entry_d;
  logic      commit;
  logic      memStalled, wbStalled;
  logic      unusedStallBits;

  assign memStalled      = (stall[StallMemBit] == Stop);
  assign wbStalled       = (stall[StallWbBit] == Stop);
  assign unusedStallBits = ^stall[3:0];

  // The entry leaving WB commits on the edge that replaces it, even if flushed.
  assign commit = entry_q.valid && !wbStalled;

  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = EmptyEntry;
    end else if (memStalled && !wbStalled) begin
      entry_d = EmptyEntry;
    end else if (!memStalled) begin
      entry_d.valid = 1'b1;
      entry_d.wd    = mem_wd;
      entry_d.wreg  = mem_wreg;
      entry_d.wdata = mem_wdata;
      entry_d.hi    = mem_hi;
      entry_d.lo    = mem_lo;
      entry_d.whilo = mem_whilo;
      entry_d.flags = mem_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      entry_q <= EmptyEntry;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign wb_wd    = entry_q.wd;
  assign wb_wreg  = entry_q.wreg;
  assign wb_wdata = entry_q.wdata;
  assign wb_hi    = entry_q.hi;
  assign wb_lo    = entry_q.lo;
  assign wb_whilo = entry_q.whilo;

  hilo_flags_reg u_hilo_flags_reg (
    .clk       (clk),
    .rst       (rst),
    .commit_i  (commit),
    .hiloEn_i  (entry_q.whilo),
    .flagsEn_i (WriteEnable),
    .hi_i      (entry_q.hi),
    .lo_i      (entry_q.lo),
    .flags_i   (entry_q.flags),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .flags_o   (flags_o)
  );

`ifdef RETIRE_CNT_EN
  logic [RegBus-1:0] retireCnt_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      retireCnt_q <= ZeroWord;
    end else if (commit) begin
      retireCnt_q <= retireCnt_q + 32'd1;
    end
  end

  assign retire_cnt = retireCnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_commit.sv
// Self-checking bench for mem_wb_commit: directed vector table, then random
// traffic against a behavioural model of the WB entry and architected state.
module tb_mem_wb_commit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_flags;
  logic        mem_whilo;
  logic [4:0]  wb_wd;
  logic        wb_wreg, wb_whilo;
  logic [31:0] wb_wdata, wb_hi, wb_lo, hi_o, lo_o, flags_o;
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int passes = 0;

  mem_wb_commit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .mem_flags (mem_flags),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .wb_whilo  (wb_whilo),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .flags_o   (flags_o)
`ifdef RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [5:0]  st;
    logic        fl;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata, hi, lo;
    logic        whilo;
    logic [31:0] flags;
    logic [4:0]  eWd;
    logic        eWreg;
    logic [31:0] eWdata;
    logic        eWhilo;
    logic [31:0] eHi, eLo, eFlags, eCnt;
  } vec_t;

  vec_t vecs[14];

  // Reference model state: the WB slot and the architected registers.
  logic        mValid, mWreg, mWhilo;
  logic [4:0]  mWd;
  logic [31:0] mWdata, mHi, mLo, mFlags, aHi, aLo, aFlags, aCnt;

  function automatic vec_t mk(input logic r, input logic [5:0] st, input logic fl,
                              input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                              input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                              input logic [31:0] flags, input logic [4:0] eWd, input logic eWreg,
                              input logic [31:0] eWdata, input logic eWhilo, input logic [31:0] eHi,
                              input logic [31:0] eLo, input logic [31:0] eFlags, input logic [31:0] eCnt);
    vec_t v;
    v.r = r; v.st = st; v.fl = fl; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.hi = hi; v.lo = lo; v.whilo = whilo; v.flags = flags;
    v.eWd = eWd; v.eWreg = eWreg; v.eWdata = eWdata; v.eWhilo = eWhilo;
    v.eHi = eHi; v.eLo = eLo; v.eFlags = eFlags; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] st, input logic fl,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                               input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                               input logic [31:0] flags);
    rst = r; stall = st; flush = fl; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_hi = hi; mem_lo = lo; mem_whilo = whilo; mem_flags = flags;
  endtask

  // Apply one rising edge to the model using the currently driven inputs.
  task automatic modelEdge();
    if (rst) begin
      mValid = 0; mWd = 0; mWreg = 0; mWdata = 0; mHi = 0; mLo = 0; mWhilo = 0; mFlags = 0;
      aHi = 0; aLo = 0; aFlags = 0; aCnt = 0;
    end else begin
      if (mValid && !stall[5]) begin
        if (mWhilo) begin aHi = mHi; aLo = mLo; end
        aFlags = mFlags;
        aCnt   = aCnt + 1;
      end
      if (flush || (stall[4] && !stall[5])) begin
        mValid = 0; mWd = 0; mWreg = 0; mWdata = 0; mHi = 0; mLo = 0; mWhilo = 0; mFlags = 0;
      end else if (!stall[4]) begin
        mValid = 1; mWd = mem_wd; mWreg = mem_wreg; mWdata = mem_wdata;
        mHi = mem_hi; mLo = mem_lo; mWhilo = mem_whilo; mFlags = mem_flags;
      end
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("rnd_wb_wd", {27'd0, wb_wd}, {27'd0, mWd});
    checkOutput("rnd_wb_wreg", {31'd0, wb_wreg}, {31'd0, mWreg});
    checkOutput("rnd_wb_wdata", wb_wdata, mWdata);
    checkOutput("rnd_wb_hi", wb_hi, mHi);
    checkOutput("rnd_wb_lo", wb_lo, mLo);
    checkOutput("rnd_wb_whilo", {31'd0, wb_whilo}, {31'd0, mWhilo});
    checkOutput("rnd_hi_o", hi_o, aHi);
    checkOutput("rnd_lo_o", lo_o, aLo);
    checkOutput("rnd_flags_o", flags_o, aFlags);
`ifdef RETIRE_CNT_EN
    checkOutput("rnd_retire_cnt", retire_cnt, aCnt);
`endif
  endtask

  initial begin
    vecs[0]  = mk(1, 6'b000000, 0, 3, 1, 32'hdead, 1, 2, 1, 32'hf,  0, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = vecs[0];
    vecs[2]  = mk(0, 6'b000000, 0, 5, 1, 32'h1234, 32'hA, 32'hB, 1, 32'h3,  5, 1, 32'h1234, 1,  0, 0, 0, 0);
    vecs[3]  = mk(0, 6'b010000, 0, 7, 1, 32'h77, 32'hC, 32'hD, 1, 32'h7,  0, 0, 0, 0,  32'hA, 32'hB, 32'h3, 1);
    vecs[4]  = vecs[3];
    vecs[5]  = mk(0, 6'b000000, 0, 9, 1, 32'h99, 32'h33, 32'h66, 1, 32'h1,  9, 1, 32'h99, 1,  32'hA, 32'hB, 32'h3, 1);
    vecs[6]  = mk(0, 6'b110000, 0, 2, 1, 32'h22, 32'h55, 32'h12, 1, 32'h8,  9, 1, 32'h99, 1,  32'hA, 32'hB, 32'h3, 1);
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = mk(0, 6'b000000, 0, 2, 1, 32'h22, 32'h55, 32'h12, 1, 32'h8,  2, 1, 32'h22, 1,  32'h33, 32'h66, 32'h1, 2);
    vecs[10] = mk(0, 6'b010000, 1, 4, 1, 32'h44, 32'h77, 32'h78, 1, 32'h2,  0, 0, 0, 0,  32'h55, 32'h12, 32'h8, 3);
    vecs[11] = mk(0, 6'b000000, 0, 6, 1, 32'h66, 32'hEE, 32'hFF, 0, 32'h20,  6, 1, 32'h66, 0,  32'h55, 32'h12, 32'h8, 3);
    vecs[12] = mk(0, 6'b000000, 0, 1, 0, 32'h1, 0, 0, 0, 32'h40,  1, 0, 32'h1, 0,  32'h55, 32'h12, 32'h20, 4);
    vecs[13] = mk(1, 6'b110000, 0, 8, 1, 32'h88, 32'h9, 32'h9, 1, 32'h9,  0, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].r, vecs[i].st, vecs[i].fl, vecs[i].wd, vecs[i].wreg, vecs[i].wdata,
                    vecs[i].hi, vecs[i].lo, vecs[i].whilo, vecs[i].flags);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_wb_wd", i), {27'd0, wb_wd}, {27'd0, vecs[i].eWd});
      checkOutput($sformatf("vec%0d_wb_wreg", i), {31'd0, wb_wreg}, {31'd0, vecs[i].eWreg});
      checkOutput($sformatf("vec%0d_wb_wdata", i), wb_wdata, vecs[i].eWdata);
      checkOutput($sformatf("vec%0d_wb_whilo", i), {31'd0, wb_whilo}, {31'd0, vecs[i].eWhilo});
      checkOutput($sformatf("vec%0d_hi_o", i), hi_o, vecs[i].eHi);
      checkOutput($sformatf("vec%0d_lo_o", i), lo_o, vecs[i].eLo);
      checkOutput($sformatf("vec%0d_flags_o", i), flags_o, vecs[i].eFlags);
`ifdef RETIRE_CNT_EN
      checkOutput($sformatf("vec%0d_retire_cnt", i), retire_cnt, vecs[i].eCnt);
`endif
    end

    // Last vector was a reset, so the model starts from the all-zero state.
    mValid = 0; mWd = 0; mWreg = 0; mWdata = 0; mHi = 0; mLo = 0; mWhilo = 0; mFlags = 0;
    aHi = 0; aLo = 0; aFlags = 0; aCnt = 0;

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    {($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15))},
                    ($urandom_range(0, 9) == 0),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                    $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
      modelEdge();
      @(posedge clk);
      @(negedge clk);
      checkAgainstModel();
    end

`ifdef RETIRE_CNT_EN
    // Counter wrap: preload the counter, load one entry and let it commit.
    applyStimulus(0, 6'b000000, 0, 5'd3, 1, 32'h5, 32'h6, 32'h7, 1, 32'h8);
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    force dut.retireCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retireCnt_q;
    aCnt = 32'hFFFF_FFFF;
    applyStimulus(0, 6'b010000, 0, 5'd4, 1, 32'h9, 32'hA, 32'hB, 1, 32'hC);
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    checkOutput("wrap_retire_cnt", retire_cnt, 32'h0);
    checkOutput("wrap_hi_o", hi_o, 32'h6);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
